// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (read-only) and data access (read/write). Each access walks IDLE -> ACCESS
// -> RESP, or IDLE -> RESP directly when the address is misaligned.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; when it is
// left undefined, DM always wins a simultaneous request.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy,
  output logic              align_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Read wait counter starts here and counts down to zero on the capture cycle.
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t            state_q;
  logic              grantDm_q;
  logic              lastGrantDm_q;
  logic              we_q;
  logic [2:0]        waitCnt_q;

  logic              anyReq_d;
  logic              grantDm_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              misaligned_d;

  // Pick the winner among the current requests and steer its access fields.
  always_comb begin
    anyReq_d     = if_req | dm_req;
    grantDm_d    = 1'b0;
    we_d         = 1'b0;
    addr_d       = '0;
    wdata_d      = '0;
    misaligned_d = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      grantDm_d = ~lastGrantDm_q;
    end else begin
      grantDm_d = dm_req;
    end
`else
    grantDm_d = dm_req;
`endif
    if (grantDm_d) begin
      addr_d  = dm_addr;
      we_d    = dm_we;
      wdata_d = dm_wdata;
    end else begin
      addr_d  = if_addr;
    end
    misaligned_d = (CHECK_ALIGN != 0) && (addr_d[1:0] != 2'b00);
  end

  // Access sequencer: every output is a register so the memory sees clean,
  // glitch-free address/data/strobe and the ports see one-cycle ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grantDm_q     <= 1'b0;
      lastGrantDm_q <= 1'b0;
      we_q          <= 1'b0;
      waitCnt_q     <= 3'd0;
      if_ack        <= 1'b0;
      dm_ack        <= 1'b0;
      align_err     <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
      mem_addr      <= '0;
      mem_wr        <= 1'b0;
      mem_datain    <= '0;
    end else begin
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      align_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            grantDm_q     <= grantDm_d;
            lastGrantDm_q <= grantDm_d;
            we_q          <= we_d;
            if (misaligned_d) begin
              state_q   <= RESP;
              if_ack    <= ~grantDm_d;
              dm_ack    <= grantDm_d;
              align_err <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              mem_addr   <= addr_d;
              mem_wr     <= we_d;
              mem_datain <= wdata_d;
              waitCnt_q  <= LAT_LAST;
            end
          end
        end
        ACCESS: begin
          if (we_q || (waitCnt_q == 3'd0)) begin
            if (!we_q) begin
              if (grantDm_q) begin
                dm_rdata <= mem_dataout;
              end else begin
                if_rdata <= mem_dataout;
              end
            end
            state_q    <= RESP;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_datain <= '0;
            if_ack     <= ~grantDm_q;
            dm_ack     <= grantDm_q;
          end else begin
            waitCnt_q <= waitCnt_q - 3'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter.
// dutA uses RD_LAT=1 with alignment checking; dutB uses RD_LAT=3 with
// alignment checking disabled. Build with MEM_ARB_RR_EN for round-robin.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        ifReq, dmReq, dmWe;
  logic [31:0] ifAddr, dmAddr, dmWdata, memDataout;
  logic        ifAck, dmAck, memWr, busy, alignErr;
  logic [31:0] ifRdata, dmRdata, memAddr, memDatain;

  logic        bIfReq, bDmReq, bDmWe;
  logic [31:0] bIfAddr, bDmAddr, bDmWdata, bMemDataout;
  logic        bIfAck, bDmAck, bMemWr, bBusy, bAlignErr;
  logic [31:0] bIfRdata, bDmRdata, bMemAddr, bMemDatain;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isDm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    int          expLat;
    logic        expAlign;
    logic        expWr;
    logic [31:0] expIfRdata;
    logic [31:0] expDmRdata;
  } vec_t;

  vec_t vecs[9];

  int          obsLat;
  logic        obsAlign;
  int          obsWrCount;
  logic [31:0] obsWrAddr, obsWrData, obsAddr1;
  logic        obsBoth, obsWrong;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .CHECK_ALIGN(1)) dutA (
    .clk(clk), .reset(reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAck), .if_rdata(ifRdata),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_ack(dmAck), .dm_rdata(dmRdata),
    .mem_addr(memAddr), .mem_wr(memWr), .mem_datain(memDatain),
    .mem_dataout(memDataout), .busy(busy), .align_err(alignErr)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .CHECK_ALIGN(0)) dutB (
    .clk(clk), .reset(reset),
    .if_req(bIfReq), .if_addr(bIfAddr), .if_ack(bIfAck), .if_rdata(bIfRdata),
    .dm_req(bDmReq), .dm_we(bDmWe), .dm_addr(bDmAddr), .dm_wdata(bDmWdata),
    .dm_ack(bDmAck), .dm_rdata(bDmRdata),
    .mem_addr(bMemAddr), .mem_wr(bMemWr), .mem_datain(bMemDatain),
    .mem_dataout(bMemDataout), .busy(bBusy), .align_err(bAlignErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Run one single-port access on dutA and record what was seen.
  task automatic applyStimulus(input vec_t v);
    int  n;
    bit  done;
    obsLat = -1; obsAlign = 1'b0; obsWrCount = 0;
    obsWrAddr = '0; obsWrData = '0; obsAddr1 = 32'hFFFF_FFFF;
    obsBoth = 1'b0; obsWrong = 1'b0;
    memDataout = v.memData;
    if (v.isDm) begin
      dmReq = 1'b1; dmWe = v.we; dmAddr = v.addr; dmWdata = v.wdata;
    end else begin
      ifReq = 1'b1; ifAddr = v.addr;
    end
    n = 0; done = 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (n == 1) obsAddr1 = memAddr;
      if (memWr) begin
        obsWrCount++; obsWrAddr = memAddr; obsWrData = memDatain;
      end
      if (ifAck && dmAck) obsBoth = 1'b1;
      if (v.isDm ? ifAck : dmAck) obsWrong = 1'b1;
      if (v.isDm ? dmAck : ifAck) begin
        obsLat = n; obsAlign = alignErr; done = 1;
      end
    end
    ifReq = 1'b0; dmReq = 1'b0; dmWe = 1'b0;
    tick();
  endtask

  task automatic runVector(input int i);
    applyStimulus(vecs[i]);
    checkOutput($sformatf("v%0d_latency", i), obsLat, vecs[i].expLat);
    checkOutput($sformatf("v%0d_align_err", i), {31'd0, obsAlign}, {31'd0, vecs[i].expAlign});
    checkOutput($sformatf("v%0d_wr_cycles", i), obsWrCount, {31'd0, vecs[i].expWr});
    if (vecs[i].expWr) begin
      checkOutput($sformatf("v%0d_wr_addr", i), obsWrAddr, vecs[i].addr);
      checkOutput($sformatf("v%0d_wr_data", i), obsWrData, vecs[i].wdata);
    end
    checkOutput($sformatf("v%0d_first_addr", i), obsAddr1, vecs[i].expAlign ? 32'd0 : vecs[i].addr);
    checkOutput($sformatf("v%0d_if_rdata", i), ifRdata, vecs[i].expIfRdata);
    checkOutput($sformatf("v%0d_dm_rdata", i), dmRdata, vecs[i].expDmRdata);
    checkOutput($sformatf("v%0d_both_ack", i), {31'd0, obsBoth}, 32'd0);
    checkOutput($sformatf("v%0d_wrong_ack", i), {31'd0, obsWrong}, 32'd0);
    checkOutput($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
  endtask

  // Both ports request reads together on dutA; report the tick of each ack.
  task automatic pairSeq(input logic [31:0] data, output int ifTick, output int dmTick, output logic both);
    int n;
    ifTick = -1; dmTick = -1; both = 1'b0; n = 0;
    memDataout = data;
    ifReq = 1'b1; ifAddr = 32'h100;
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h200;
    while ((ifTick < 0 || dmTick < 0) && n < 20) begin
      tick();
      n++;
      if (ifAck && dmAck) both = 1'b1;
      if (ifAck && ifTick < 0) begin ifTick = n; ifReq = 1'b0; end
      if (dmAck && dmTick < 0) begin dmTick = n; dmReq = 1'b0; end
    end
    ifReq = 1'b0; dmReq = 1'b0;
    tick();
  endtask

  initial begin
    int   ifT, dmT, n, ackTick;
    logic both, sawAck, alignAt;

    //      isDm we   addr          wdata         memData       lat al wr ifRdata       dmRdata
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 32'h55555555, 2, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h44, 32'h0,        32'hCAFEF00D, 2, 1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 32'h42, 32'h0,        32'h77777777, 1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 32'h43, 32'hAAAA5555, 32'h77777777, 1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b0, 32'h11, 32'h0,        32'h66666666, 1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h0BADF00D, 2, 1'b0, 1'b0, 32'h0BADF00D, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 1'b1, 32'h7C, 32'hFFFF0000, 32'h12121212, 2, 1'b0, 1'b1, 32'h0BADF00D, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 1'b0, 32'h30, 32'h0,        32'h31313131, 2, 1'b0, 1'b0, 32'h31313131, 32'hA5A5A5A5};

    reset = 1'b1;
    ifReq = 0; dmReq = 0; dmWe = 0; ifAddr = 0; dmAddr = 0; dmWdata = 0; memDataout = 0;
    bIfReq = 0; bDmReq = 0; bDmWe = 0; bIfAddr = 0; bDmAddr = 0; bDmWdata = 0; bMemDataout = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_acks", {30'd0, ifAck, dmAck}, 32'd0);
    checkOutput("reset_align", {31'd0, alignErr}, 32'd0);
    checkOutput("reset_if_rdata", ifRdata, 32'd0);
    checkOutput("reset_dm_rdata", dmRdata, 32'd0);
    checkOutput("reset_mem", memAddr | memDatain | {31'd0, memWr}, 32'd0);

    for (int i = 0; i < 8; i++) runVector(i);

    // Last grant is DM here: fixed priority still picks DM, round-robin picks IF.
    pairSeq(32'hA5A5A5A5, ifT, dmT, both);
`ifdef MEM_ARB_RR_EN
    checkOutput("pairA_if_tick", ifT, 32'd2);
    checkOutput("pairA_dm_tick", dmT, 32'd5);
`else
    checkOutput("pairA_if_tick", ifT, 32'd5);
    checkOutput("pairA_dm_tick", dmT, 32'd2);
`endif
    checkOutput("pairA_both_ack", {31'd0, both}, 32'd0);
    checkOutput("pairA_if_rdata", ifRdata, 32'hA5A5A5A5);
    checkOutput("pairA_dm_rdata", dmRdata, 32'hA5A5A5A5);

    // Lone IF access leaves last grant = IF, so both builds serve DM first.
    runVector(8);
    pairSeq(32'h5A5A5A5A, ifT, dmT, both);
    checkOutput("pairB_if_tick", ifT, 32'd5);
    checkOutput("pairB_dm_tick", dmT, 32'd2);
    checkOutput("pairB_both_ack", {31'd0, both}, 32'd0);

    // dutB: RD_LAT=3 read at 0x80, data must be the value present on the third wait cycle.
    bMemDataout = 32'h0; bIfReq = 1'b1; bIfAddr = 32'h80;
    tick(); checkOutput("b_lat3_addr_t1", bMemAddr, 32'h80); bMemDataout = 32'h11111111; bIfAddr = 32'h99;
    tick(); checkOutput("b_lat3_addr_t2", bMemAddr, 32'h80); bMemDataout = 32'h22222222;
    tick(); checkOutput("b_lat3_addr_t3", bMemAddr, 32'h80); bMemDataout = 32'h33333333;
    checkOutput("b_lat3_no_early_ack", {31'd0, bIfAck}, 32'd0);
    tick(); bMemDataout = 32'h44444444;
    checkOutput("b_lat3_ack_t4", {31'd0, bIfAck}, 32'd1);
    checkOutput("b_lat3_rdata", bIfRdata, 32'h33333333);
    checkOutput("b_lat3_mem_idle", bMemAddr, 32'd0);
    bIfReq = 1'b0;
    tick();

    // dutB: misaligned DM read passes through when alignment checking is off.
    bDmReq = 1'b1; bDmWe = 1'b0; bDmAddr = 32'h42; bMemDataout = 32'h0F0F0F0F;
    n = 0; ackTick = -1; alignAt = 1'b1;
    while (ackTick < 0 && n < 20) begin
      tick();
      n++;
      if (n == 1) checkOutput("b_noalign_addr", bMemAddr, 32'h42);
      if (bDmAck) begin ackTick = n; alignAt = bAlignErr; bDmReq = 1'b0; end
    end
    bDmReq = 1'b0;
    checkOutput("b_noalign_latency", ackTick, 32'd4);
    checkOutput("b_noalign_align_err", {31'd0, alignAt}, 32'd0);
    checkOutput("b_noalign_rdata", bDmRdata, 32'h0F0F0F0F);
    tick();

    // dutA: reset while a write strobe is on the memory drops it immediately.
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h60; dmWdata = 32'h13579BDF;
    tick();
    checkOutput("rstwr_strobe", {31'd0, memWr}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; dmReq = 1'b0; dmWe = 1'b0;
    checkOutput("rstwr_mem_wr", {31'd0, memWr}, 32'd0);
    checkOutput("rstwr_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstwr_ack", {31'd0, dmAck}, 32'd0);

    // dutB: reset two cycles into an RD_LAT=3 read returns to idle with no ack.
    bIfReq = 1'b1; bIfAddr = 32'h80; bMemDataout = 32'h99999999;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; bIfReq = 1'b0;
    checkOutput("rstrd_busy", {31'd0, bBusy}, 32'd0);
    checkOutput("rstrd_mem", bMemAddr | bMemDatain | {31'd0, bMemWr}, 32'd0);
    sawAck = bIfAck | bDmAck;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bIfAck || bDmAck) sawAck = 1'b1;
    end
    checkOutput("rstrd_no_ack", {31'd0, sawAck}, 32'd0);
    checkOutput("rstrd_rdata", bIfRdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
